// File: rtl/ripple_count_capture_pkg.sv
// Shared types and default sizing for the ripple counter capture block.
// The defaults match a 4-bit JK ripple counter source.
package ripple_count_capture_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        OFFER  = 1'b1
    } state_t;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 2;
    localparam int DEF_WRAP_W        = 8;

endpackage

// File: rtl/ripple_count_capture_if.sv
// Output side of the ripple count capture: valid/ready count plus wrap status.
// master = capture block, slave = consumer.
interface ripple_count_capture_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) ();
    logic              out_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_count;
    logic [WRAP_W-1:0] out_wraps;
    logic              wrap_pulse;
    logic              settled;

    modport master (
        input  out_ready,
        output out_valid,
        output out_count,
        output out_wraps,
        output wrap_pulse,
        output settled
    );

    modport slave (
        output out_ready,
        input  out_valid,
        input  out_count,
        input  out_wraps,
        input  wrap_pulse,
        input  settled
    );
endinterface

// File: rtl/ripple_count_capture_sync_bus.sv
// Multi-bit flop synchronizer, SYNC_STAGES deep, async reset to zero.
// Bits may resolve on different cycles; downstream filtering handles skew.
module ripple_count_capture_sync_bus #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/ripple_count_capture.sv
// Captures settled values of an asynchronous ripple counter and offers them
// on valid/ready, counting 15->0 style wrap-arounds.
//   state  | meaning
//   SETTLE | waiting for a settled synchronized value that differs from the last
//   OFFER  | holding out_count/out_valid until the consumer takes it
module ripple_count_capture
    import ripple_count_capture_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int WRAP_W        = DEF_WRAP_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      q_in,
    ripple_count_capture_if.master bus
);

    localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [WIDTH-1:0]  w_s;
    logic [WIDTH-1:0]  r_p;
    logic [CNT_W-1:0]  r_stable_cnt;
    logic              w_s_eq_p;
    logic              w_settled;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic [WIDTH-1:0]  r_out_count;
    logic [WIDTH-1:0]  w_out_count_nxt;
    logic [WIDTH-1:0]  r_last_count;
    logic [WIDTH-1:0]  w_last_count_nxt;
    logic [WRAP_W-1:0] r_out_wraps;
    logic [WRAP_W-1:0] w_out_wraps_nxt;
    logic              r_wrap_pulse;
    logic              w_wrap_pulse_nxt;

    ripple_count_capture_sync_bus #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (q_in),
        .o_q   (w_s)
    );

    assign w_s_eq_p  = (w_s == r_p);
    assign w_settled = (r_stable_cnt == CNT_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_p          <= '0;
            r_stable_cnt <= '0;
        end else begin
            r_p <= w_s;
            if (!w_s_eq_p) begin
                r_stable_cnt <= '0;
            end else if (r_stable_cnt != CNT_MAX) begin
                r_stable_cnt <= r_stable_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= SETTLE;
            r_out_valid  <= 1'b0;
            r_out_count  <= '0;
            r_last_count <= '0;
            r_out_wraps  <= '0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_count  <= w_out_count_nxt;
            r_last_count <= w_last_count_nxt;
            r_out_wraps  <= w_out_wraps_nxt;
            r_wrap_pulse <= w_wrap_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_out_valid_nxt  = r_out_valid;
        w_out_count_nxt  = r_out_count;
        w_last_count_nxt = r_last_count;
        w_out_wraps_nxt  = r_out_wraps;
        w_wrap_pulse_nxt = 1'b0;
        case (r_state)
            SETTLE: begin
                // settled lags s by a cycle, so also require s to still match p;
                // otherwise a one-cycle glitch right after a stable run is taken.
                if (w_settled && w_s_eq_p && (w_s != r_last_count)) begin
                    w_out_count_nxt  = w_s;
                    w_last_count_nxt = w_s;
                    w_out_valid_nxt  = 1'b1;
                    w_state_nxt      = OFFER;
                    if (w_s < r_last_count) begin
                        w_out_wraps_nxt  = r_out_wraps + 1'b1;
                        w_wrap_pulse_nxt = 1'b1;
                    end
                end
            end
            OFFER: begin
                if (r_out_valid && bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = SETTLE;
                end
            end
        endcase
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_count  = r_out_count;
    assign bus.out_wraps  = r_out_wraps;
    assign bus.wrap_pulse = r_wrap_pulse;
    assign bus.settled    = w_settled;

endmodule
